alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Downstream stage of the 32-bit ALU. It captures each ALU result with its carry/overflow, opcode and destination tag.
- Derives Z/N/C/V flags and buffers entries in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Maintains the architectural status-flag register consumed by branch logic; feeds register writeback.

Parameters:
WIDTH, 32, datapath width of Result
TAG_W, 5, destination register tag width

Ports:
Clk  input  1  clock, all state on rising edge
Rst_n  input  1  asynchronous active-low reset
Flush  input  1  synchronous discard of all buffered entries
In_valid  input  1  ALU output valid
In_ready  output  1  stage can accept an entry
In_result  input  WIDTH  ALU Result
In_cout  input  1  ALU carry-out
In_ovf  input  1  ALU signed overflow
In_opsel  input  4  ALU opcode (alu_pkg::opsel_t)
In_tag  input  TAG_W  destination register
In_setflags  input  1  entry updates status flags when retired
Out_valid  output  1  head entry valid
Out_ready  input  1  writeback accepts head
Out_result  output  WIDTH  head result
Out_tag  output  TAG_W  head tag
Out_flags  output  4  head flags {N,Z,C,V}
Out_illegal  output  1  head opcode not defined in alu_pkg
Status_flags  output  4  architectural {N,Z,C,V}

Behaviour:
- Reset (Rst_n=0, async): state EMPTY; In_ready=0, Out_valid=0, Out_result=0, Out_tag=0, Out_flags=0, Out_illegal=0, Status_flags=0.
- In_ready is registered. It rises on the first Clk edge after reset release.
- Push = In_valid & In_ready. Pop = Out_valid & Out_ready.
- FSM states: EMPTY, ONE, FULL. In_ready = (state != FULL). Out_valid = (state != EMPTY).
  - EMPTY: push -> ONE.
  - ONE: push&!pop -> FULL; pop&!push -> EMPTY; push&pop -> ONE, with the new entry becoming head.
  - FULL: pop -> ONE. Push is impossible in FULL.
- Latency: an entry pushed at edge N is on Out_* after edge N when the buffer was empty or popped in the same cycle. Sustained throughput is 1 entry/cycle with Out_ready held high. Order is strictly FIFO.
- Out_* are driven directly from head-entry registers; there is no combinational path In_* -> Out_*. In_ready depends on state only, not on Out_ready.
- Flag derivation happens at push:
  - Z = (In_result == 0).
  - N = In_result[WIDTH-1].
  - C = In_cout for ADD, SUB, SHL; otherwise 0.
  - V = In_ovf for ADD, SUB; otherwise 0.
- Illegal opcode (not in package enum): the entry is stored normally, C=V=0, and Out_illegal=1 for that entry.
- Status_flags update on pop when the head's setflags bit=1: Status_flags <= head flags, visible the cycle after pop. Entries with setflags=0 leave it unchanged.
- Flush: next edge -> EMPTY. It overrides a push and a pop in the same cycle, and no Status_flags update occurs that cycle. Status_flags is not cleared by Flush. Payload registers may retain stale data, but Out_valid=0.
- Reset mid-transfer: all entries are discarded immediately, with no partial update.
- Out_* hold stable while Out_valid=1 and Out_ready=0.

Decomposition:
- alu_pkg holds the shared definitions:
  - typedef enum logic[3:0] opsel_t: ADD=4'h0, SUB=4'h1, AND=4'h8, OR=4'h9, XOR=4'hA, NOT=4'hB, SHL=4'hD.
  - FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0 index constants.
  - typedef struct packed alu_entry_t {result, tag, flags, illegal, setflags}.
  - This enum replaces any locally declared opsel types in the ALU testbenches.
- Sub-module alu_flag_gen (combinational): In_result/In_cout/In_ovf/In_opsel -> flags, illegal. The FSM and buffer stay in alu_result_stage.

Test Plan:
1. Reset then single ADD: result=32'h0, cout=1, setflags=1, Out_ready=1 -> Out_valid one cycle later, Out_flags=4'b0110; Status_flags=4'b0110 the cycle after pop.
2. Backpressure: push 3 back-to-back (AND 32'hFFFF_0000, OR 32'h1, XOR 32'h0) with Out_ready=0 -> In_ready=0 after 2nd push, 3rd held. Release Out_ready -> outputs in order, flags 4'b1000, 4'b0000, 4'b0100, all C=V=0.
3. Streaming: 16 SHL entries with In_valid=Out_ready=1 every cycle -> 16 outputs in 16 consecutive cycles; C follows cout, V=0.
4. Simultaneous push+pop in ONE: head ADD tag 3, push SUB tag 7 -> next cycle Out_tag=7, state ONE, In_ready=1.
5. Flush with FULL buffer plus concurrent push and pop -> next cycle Out_valid=0, In_ready=1, Status_flags unchanged.
6. Opsel=4'hF, result=32'h8000_0000, cout=1, ovf=1 -> Out_illegal=1, Out_flags=4'b1000. Assert Rst_n=0 mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU and its result stage.
//   opsel_t      - ALU opcode encoding (the only legal opcodes)
//   FLAG_*       - bit positions inside a 4-bit {N,Z,C,V} flag vector
//   alu_entry_t  - one buffered ALU result as held by alu_result_stage
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_TAG_W = 5;

  typedef enum logic [3:0] {
    ADD = 4'h0,
    SUB = 4'h1,
    AND = 4'h8,
    OR  = 4'h9,
    XOR = 4'hA,
    NOT = 4'hB,
    SHL = 4'hD
  } opsel_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] result;
    logic [ALU_TAG_W-1:0] tag;
    logic [3:0]           flags;
    logic                 illegal;
    logic                 setflags;
  } alu_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: combinational {N,Z,C,V} derivation for one ALU result.
//   result  - ALU result
//   cout    - ALU carry-out (meaningful for ADD/SUB/SHL only)
//   ovf     - ALU signed overflow (meaningful for ADD/SUB only)
//   opsel   - ALU opcode
//   flags   - derived {N,Z,C,V}
//   illegal - opcode is not one of alu_pkg::opsel_t
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] result,
  input  logic             cout,
  input  logic             ovf,
  input  logic [3:0]       opsel,
  output logic [3:0]       flags,
  output logic             illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // the block leaves a variable unassigned (which would infer a latch).
    flags         = '0;
    illegal       = 1'b0;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
    case (opsel)
      ADD, SUB: begin
        flags[FLAG_C] = cout;
        flags[FLAG_V] = ovf;
      end
      SHL:                flags[FLAG_C] = cout;
      AND, OR, XOR, NOT:  ;  // logic ops: C and V stay clear
      default:            illegal = 1'b1;  // stored anyway, C/V clear
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: captures ALU results into a 2-entry skid buffer, derives
// flags at push time, and maintains the architectural status-flag register.
//   clk, rst_n     - clock, asynchronous active-low reset
//   flush          - discard all buffered entries on the next edge
//   in_valid/in_ready, in_result, in_cout, in_ovf, in_opsel, in_tag,
//   in_setflags    - upstream handshake and ALU result fields
//   out_valid/out_ready, out_result, out_tag, out_flags, out_illegal
//                  - head entry towards register writeback
//   status_flags   - architectural {N,Z,C,V}, updated when a setflags
//                    entry is popped
// The entry layout comes from alu_pkg, so WIDTH/TAG_W must match the
// package widths.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int TAG_W = ALU_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_cout,
  input  logic             in_ovf,
  input  logic [3:0]       in_opsel,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_setflags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags,
  output logic             out_illegal,
  output logic [3:0]       status_flags
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t     state_q, state_d;
  logic       in_ready_q;
  alu_entry_t head_q, tail_q, new_entry;
  logic [3:0] status_q;
  logic [3:0] new_flags;
  logic       new_illegal;
  logic       push, pop;
  logic       load_head_new, load_head_tail, load_tail;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .result  (in_result),
    .cout    (in_cout),
    .ovf     (in_ovf),
    .opsel   (in_opsel),
    .flags   (new_flags),
    .illegal (new_illegal)
  );

  always_comb begin
    new_entry = '{result:   in_result,
                  tag:      in_tag,
                  flags:    new_flags,
                  illegal:  new_illegal,
                  setflags: in_setflags};
  end

  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  // Next state and buffer load strobes. Head is always the oldest entry;
  // tail is only occupied in FULL.
  always_comb begin
    state_d        = state_q;
    load_head_new  = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    case (state_q)
      EMPTY: if (push) begin
        state_d       = ONE;
        load_head_new = 1'b1;
      end
      ONE: begin
        if (push && pop) begin
          load_head_new = 1'b1;  // head leaves, new entry takes its place
        end else if (push) begin
          state_d   = FULL;
          load_tail = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: if (pop) begin
        state_d        = ONE;
        load_head_tail = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d        = EMPTY;
      load_head_new  = 1'b0;
      load_head_tail = 1'b0;
      load_tail      = 1'b0;
    end
  end

  // in_ready is registered from the next state, so it is low in reset and
  // rises on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // NOTE: the payload registers are reset because out_* must read zero
  // while rst_n is low; tail is reset too so no X ever reaches head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head_new)       head_q <= new_entry;
      else if (load_head_tail) head_q <= tail_q;
      if (load_tail)           tail_q <= new_entry;
    end
  end

  // Status flags retire with the entry; flush suppresses the update even
  // if a pop coincides with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
    end else if (pop && head_q.setflags && !flush) begin
      status_q <= head_q.flags;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_result   = head_q.result;
  assign out_tag      = head_q.tag;
  assign out_flags    = head_q.flags;
  assign out_illegal  = head_q.illegal;
  assign status_flags = status_q;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_cout;
  logic             in_ovf;
  logic [3:0]       in_opsel;
  logic [TAG_W-1:0] in_tag;
  logic             in_setflags;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_flags;
  logic             out_illegal;
  logic [3:0]       status_flags;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_cout      (in_cout),
    .in_ovf       (in_ovf),
    .in_opsel     (in_opsel),
    .in_tag       (in_tag),
    .in_setflags  (in_setflags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_tag      (out_tag),
    .out_flags    (out_flags),
    .out_illegal  (out_illegal),
    .status_flags (status_flags)
  );

  typedef struct {
    logic [3:0]  opsel;
    logic [31:0] result;
    logic        cout;
    logic        ovf;
    logic [4:0]  tag;
    logic        setflags;
    logic [3:0]  exp_flags;
    logic        exp_illegal;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] res,
                       input logic c, input logic v, input logic [4:0] tag,
                       input logic sf);
    in_valid    = 1'b1;
    in_opsel    = op;
    in_result   = res;
    in_cout     = c;
    in_ovf      = v;
    in_tag      = tag;
    in_setflags = sf;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, " in_ready"},     32'(in_ready),     32'd0);
    check({pfx, " out_valid"},    32'(out_valid),    32'd0);
    check({pfx, " out_result"},   out_result,        32'd0);
    check({pfx, " out_tag"},      32'(out_tag),      32'd0);
    check({pfx, " out_flags"},    32'(out_flags),    32'd0);
    check({pfx, " out_illegal"},  32'(out_illegal),  32'd0);
    check({pfx, " status_flags"}, 32'(status_flags), 32'd0);
  endtask

  initial begin
    logic [3:0]  model_status;
    logic [31:0] res;
    logic [3:0]  exp_f;

    //          opsel  result         c     v     tag    sf    flags    ill
    vecs[0] = '{4'h0, 32'h0000_0000, 1'b1, 1'b0, 5'd1,  1'b1, 4'b0110, 1'b0};
    vecs[1] = '{4'h1, 32'h8000_0000, 1'b0, 1'b1, 5'd2,  1'b1, 4'b1001, 1'b0};
    vecs[2] = '{4'h8, 32'hFFFF_0000, 1'b1, 1'b1, 5'd3,  1'b0, 4'b1000, 1'b0};
    vecs[3] = '{4'h9, 32'h0000_0001, 1'b1, 1'b1, 5'd4,  1'b1, 4'b0000, 1'b0};
    vecs[4] = '{4'hA, 32'h0000_0000, 1'b1, 1'b1, 5'd5,  1'b1, 4'b0100, 1'b0};
    vecs[5] = '{4'hB, 32'h7FFF_FFFF, 1'b1, 1'b1, 5'd6,  1'b0, 4'b0000, 1'b0};
    vecs[6] = '{4'hD, 32'hF000_0000, 1'b1, 1'b1, 5'd7,  1'b1, 4'b1010, 1'b0};
    vecs[7] = '{4'hF, 32'h8000_0000, 1'b1, 1'b1, 5'd8,  1'b1, 4'b1000, 1'b1};
    vecs[8] = '{4'h2, 32'h0000_0000, 1'b1, 1'b1, 5'd9,  1'b0, 4'b0100, 1'b1};
    vecs[9] = '{4'h0, 32'h0000_0010, 1'b0, 1'b1, 5'd10, 1'b1, 4'b0001, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_result = '0; in_cout = 1'b0; in_ovf = 1'b0; in_opsel = '0;
    in_tag = '0; in_setflags = 1'b0;
    model_status = 4'b0000;

    // Reset state and in_ready rising one edge after release
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready before first edge", 32'(in_ready), 32'd0);
    step();
    check("in_ready after first edge", 32'(in_ready), 32'd1);
    check("out_valid idle", 32'(out_valid), 32'd0);

    // Table: push one entry, inspect head, pop, inspect status
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].opsel, vecs[i].result, vecs[i].cout, vecs[i].ovf,
            vecs[i].tag, vecs[i].setflags);
      out_ready = 1'b0;
      step();
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d out_result", i), out_result, vecs[i].result);
      check($sformatf("vec%0d out_tag", i), 32'(out_tag), 32'(vecs[i].tag));
      check($sformatf("vec%0d out_flags", i), 32'(out_flags), 32'(vecs[i].exp_flags));
      check($sformatf("vec%0d out_illegal", i), 32'(out_illegal), 32'(vecs[i].exp_illegal));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      if (vecs[i].setflags) model_status = vecs[i].exp_flags;
      check($sformatf("vec%0d popped", i), 32'(out_valid), 32'd0);
      check($sformatf("vec%0d status", i), 32'(status_flags), 32'(model_status));
    end

    // Backpressure: three pushes with out_ready low, then drain in order
    out_ready = 1'b0;
    drive(4'h8, 32'hFFFF_0000, 1'b1, 1'b1, 5'd11, 1'b0);
    step();
    check("bp in_ready after 1st", 32'(in_ready), 32'd1);
    drive(4'h9, 32'h0000_0001, 1'b1, 1'b1, 5'd12, 1'b0);
    step();
    check("bp in_ready after 2nd", 32'(in_ready), 32'd0);
    check("bp head flags", 32'(out_flags), 32'b1000);
    drive(4'hA, 32'h0000_0000, 1'b1, 1'b1, 5'd13, 1'b0);
    step();
    check("bp in_ready held", 32'(in_ready), 32'd0);
    check("bp head tag stable", 32'(out_tag), 32'd11);
    check("bp head result stable", out_result, 32'hFFFF_0000);
    out_ready = 1'b1;
    step();
    check("bp 2nd tag", 32'(out_tag), 32'd12);
    check("bp 2nd flags", 32'(out_flags), 32'b0000);
    check("bp in_ready reopened", 32'(in_ready), 32'd1);
    step();
    check("bp 3rd tag", 32'(out_tag), 32'd13);
    check("bp 3rd flags", 32'(out_flags), 32'b0100);
    in_valid = 1'b0;
    step();
    check("bp drained", 32'(out_valid), 32'd0);
    check("bp status unchanged", 32'(status_flags), 32'(model_status));

    // Streaming: 16 SHL entries, one per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      res = 32'(i) * 32'h1000_0001;
      drive(4'hD, res, i[0], 1'b1, 5'(i), 1'b1);
      step();
      exp_f = {res[31], res == 32'd0, i[0], 1'b0};
      check($sformatf("stream%0d valid", i), 32'(out_valid), 32'd1);
      check($sformatf("stream%0d tag", i), 32'(out_tag), 32'(i));
      check($sformatf("stream%0d flags", i), 32'(out_flags), 32'(exp_f));
      model_status = exp_f;
    end
    in_valid = 1'b0;
    step();
    check("stream drained", 32'(out_valid), 32'd0);
    check("stream status", 32'(status_flags), 32'b1010);

    // Push and pop together while ONE: new entry becomes head
    out_ready = 1'b0;
    drive(4'h0, 32'h0000_0001, 1'b0, 1'b0, 5'd3, 1'b1);
    step();
    check("pp head tag 3", 32'(out_tag), 32'd3);
    drive(4'h1, 32'h8000_0000, 1'b1, 1'b0, 5'd7, 1'b1);
    out_ready = 1'b1;
    step();
    check("pp head tag 7", 32'(out_tag), 32'd7);
    check("pp out_valid", 32'(out_valid), 32'd1);
    check("pp in_ready", 32'(in_ready), 32'd1);
    check("pp head flags", 32'(out_flags), 32'b1010);
    check("pp status from ADD", 32'(status_flags), 32'b0000);
    in_valid = 1'b0;
    step();
    check("pp status from SUB", 32'(status_flags), 32'b1010);
    model_status = 4'b1010;

    // Flush from FULL with concurrent push/pop
    out_ready = 1'b0;
    drive(4'h0, 32'h0000_0000, 1'b1, 1'b0, 5'd20, 1'b1);
    step();
    drive(4'h9, 32'h0000_0001, 1'b0, 1'b0, 5'd21, 1'b1);
    step();
    check("flush pre full", 32'(in_ready), 32'd0);
    drive(4'hA, 32'h0000_0000, 1'b0, 1'b0, 5'd22, 1'b1);
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    check("flush full out_valid", 32'(out_valid), 32'd0);
    check("flush full in_ready", 32'(in_ready), 32'd1);
    check("flush full status", 32'(status_flags), 32'(model_status));

    // Flush from ONE while a push and pop would both happen
    out_ready = 1'b0;
    drive(4'hA, 32'h0000_0000, 1'b0, 1'b0, 5'd23, 1'b1);
    step();
    drive(4'h0, 32'h0000_0000, 1'b1, 1'b0, 5'd24, 1'b1);
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush one out_valid", 32'(out_valid), 32'd0);
    check("flush one status", 32'(status_flags), 32'(model_status));
    step();
    check("flush one stays empty", 32'(out_valid), 32'd0);

    // Illegal opcode, then asynchronous reset with the buffer full
    out_ready = 1'b0;
    drive(4'hF, 32'h8000_0000, 1'b1, 1'b1, 5'd25, 1'b1);
    step();
    check("illegal flag", 32'(out_illegal), 32'd1);
    check("illegal flags", 32'(out_flags), 32'b1000);
    drive(4'h0, 32'h1234_5678, 1'b1, 1'b1, 5'd26, 1'b1);
    step();
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post reset in_ready", 32'(in_ready), 32'd1);
    check("post reset out_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
